// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the multi-cycle ALU and its datapath.
package alu_pkg;

   // Opcodes: the original 3-bit AND/OR/ADD/SUB/SLT codes widened to 4 bits.
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_NOR  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_MUL  = 4'b1011;

   // Handshake FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle combinational datapath: every opcode except MUL, plus flags.
module alu_comb
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [3:0]            op,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  overflow,
   output logic                  carry_out,
   output logic                  zero
);

   localparam int MSB = DATA_WIDTH - 1;

   logic signed [DATA_WIDTH-1:0] a_s;
   logic        [DATA_WIDTH:0]   sum;
   logic        [DATA_WIDTH:0]   diff;
   logic        [SHAMT_W-1:0]    shamt;
   logic                         add_ovf;
   logic                         sub_ovf;

   // ADD and SUB share one extra bit so the carry falls out of bit DATA_WIDTH.
   assign a_s     = a;
   assign shamt   = b[SHAMT_W-1:0];
   assign sum     = {1'b0, a} + {1'b0, b};
   assign diff    = {1'b0, a} + {1'b0, ~b} + (DATA_WIDTH+1)'(1);
   assign add_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
   assign sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);

   // Opcode decode; flags are only meaningful for ADD/SUB and are zero otherwise.
   always_comb begin
      result    = '0;
      overflow  = 1'b0;
      carry_out = 1'b0;
      case (op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOR:  result = ~(a | b);
         OP_ADD: begin
            result    = sum[MSB:0];
            overflow  = add_ovf;
            carry_out = sum[DATA_WIDTH];
         end
         OP_SUB: begin
            result    = diff[MSB:0];
            overflow  = sub_ovf;
            carry_out = diff[DATA_WIDTH];
         end
         OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, diff[MSB] ^ sub_ovf};
         OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, ~diff[DATA_WIDTH]};
         OP_SLL:  result = a << shamt;
         OP_SRL:  result = a >> shamt;
         OP_SRA:  result = a_s >>> shamt;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_mc.sv
// Registered ALU with valid/ready handshakes and a fixed-latency shift-add multiplier.
module alu_mc
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic [3:0]            ALUop,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] Result,
   output logic                  Overflow,
   output logic                  CarryOut,
   output logic                  Zero
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   state_t                  state, state_nxt;
   logic [DATA_WIDTH-1:0]   acc, mcand, mplier, acc_nxt;
   logic [CNT_W-1:0]        count;
   logic [DATA_WIDTH-1:0]   c_result;
   logic                    c_ovf, c_carry, c_zero;
   logic                    accept, is_mul, last_step;

   alu_comb #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHAMT_W    (SHAMT_W)
   ) u_comb (
      .a         (A),
      .b         (B),
      .op        (ALUop),
      .result    (c_result),
      .overflow  (c_ovf),
      .carry_out (c_carry),
      .zero      (c_zero)
   );

   assign is_mul    = (ALUop == OP_MUL);
   assign accept    = in_valid && in_ready;
   assign last_step = (state == ST_BUSY) && (count == CNT_W'(1));
   assign acc_nxt   = acc + (mplier[0] ? mcand : '0);

   // FSM state register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Next-state and handshake outputs; ready/valid decode purely from state.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = is_mul ? ST_BUSY : ST_DONE;
         end
         ST_BUSY: begin
            if (count == CNT_W'(1)) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Operand capture, one multiply step per BUSY cycle, and the result/flag registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         count    <= '0;
         Result   <= '0;
         Overflow <= 1'b0;
         CarryOut <= 1'b0;
         Zero     <= 1'b0;
      end else if (accept) begin
         if (is_mul) begin
            acc    <= '0;
            mcand  <= A;
            mplier <= B;
            count  <= CNT_W'(DATA_WIDTH);
         end else begin
            Result   <= c_result;
            Overflow <= c_ovf;
            CarryOut <= c_carry;
            Zero     <= c_zero;
         end
      end else if (state == ST_BUSY) begin
         acc    <= acc_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count - CNT_W'(1);
         if (last_step) begin
            Result   <= acc_nxt;
            Overflow <= 1'b0;
            CarryOut <= 1'b0;
            Zero     <= (acc_nxt == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed, table-driven bench for alu_mc plus hand-written handshake and reset sequences.
module tb_alu_mc;
   import alu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic [3:0]   ALUop = 4'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] Result;
   logic         Overflow, CarryOut, Zero;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         ovf;
      logic         cy;
      logic         z;
      int           lat;
   } vec_t;

   vec_t vecs[23];

   alu_mc #(.DATA_WIDTH(W)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .ALUop     (ALUop),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Result    (Result),
      .Overflow  (Overflow),
      .CarryOut  (CarryOut),
      .Zero      (Zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present one operation, wait for acceptance, then count cycles until out_valid.
   task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
      ALUop    = op;
      A        = a;
      B        = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat <= 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic retire(input string name);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({name, "_in_ready_after"}, W'(in_ready), W'(1));
      check({name, "_out_valid_after"}, W'(out_valid), W'(0));
   endtask

   initial begin
      int  lat;
      bit  seen;
      logic [W-1:0] held;

      //            op       a              b              res            ovf   cy    z     lat
      vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0, 1};
      vecs[1]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b1, 1};
      vecs[2]  = '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b1, 1};
      vecs[3]  = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1};
      vecs[4]  = '{OP_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1};
      vecs[5]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
      vecs[6]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 1};
      vecs[7]  = '{OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
      vecs[8]  = '{OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
      vecs[9]  = '{OP_SLT,  32'h00000001, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1};
      vecs[10] = '{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1};
      vecs[11] = '{OP_OR,   32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1};
      vecs[12] = '{OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1};
      vecs[13] = '{OP_NOR,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b0, 1'b0, 1'b1, 1};
      vecs[14] = '{OP_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 1'b0, 1};
      vecs[15] = '{OP_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 1'b0, 1};
      vecs[16] = '{OP_SLL,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0, 1'b0, 1};
      vecs[17] = '{OP_SLL,  32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 1'b0, 1};
      vecs[18] = '{OP_SRA,  32'h7FFFFFFF, 32'h0000001F, 32'h00000000, 1'b0, 1'b0, 1'b1, 1};
      vecs[19] = '{4'b1100, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 1'b0, 1'b1, 1};
      vecs[20] = '{OP_MUL,  32'd1234,       32'd5678,       32'd7006652,   1'b0, 1'b0, 1'b0, 33};
      vecs[21] = '{OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 33};
      vecs[22] = '{OP_MUL,  32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 1'b0, 1'b1, 33};

      // Reset state
      #1;
      check("rst_in_ready", W'(in_ready), W'(1));
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_result", Result, '0);
      check("rst_flags", W'({Overflow, CarryOut, Zero}), W'(0));
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Table of single operations
      for (int i = 0; i < 23; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         check($sformatf("v%0d_latency", i), W'(lat), W'(vecs[i].lat));
         check($sformatf("v%0d_result", i), Result, vecs[i].res);
         check($sformatf("v%0d_overflow", i), W'(Overflow), W'(vecs[i].ovf));
         check($sformatf("v%0d_carry", i), W'(CarryOut), W'(vecs[i].cy));
         check($sformatf("v%0d_zero", i), W'(Zero), W'(vecs[i].z));
         retire($sformatf("v%0d", i));
      end

      // MUL with backpressure and a competing request held in DONE
      do_op(OP_MUL, 32'd1234, 32'd5678, lat);
      check("bp_latency", W'(lat), W'(33));
      check("bp_result", Result, 32'd7006652);
      ALUop    = OP_ADD;
      A        = 32'd1;
      B        = 32'd1;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp_hold%0d_result", k), Result, 32'd7006652);
         check($sformatf("bp_hold%0d_in_ready", k), W'(in_ready), W'(0));
         check($sformatf("bp_hold%0d_out_valid", k), W'(out_valid), W'(1));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("bp_retire_in_ready", W'(in_ready), W'(1));
      check("bp_retire_out_valid", W'(out_valid), W'(0));
      @(posedge clk);
      #1;
      check("bp_no_accept_out_valid", W'(out_valid), W'(0));
      check("bp_idle_result_held", Result, 32'd7006652);

      // Reset while a multiply is in BUSY
      held = Result;
      check("rst_mid_prior_nonzero", W'(held != '0), W'(1));
      ALUop    = OP_MUL;
      A        = 32'd3;
      B        = 32'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("rst_mid_busy_in_ready", W'(in_ready), W'(0));
      resetn = 1'b0;
      #1;
      check("rst_mid_out_valid", W'(out_valid), W'(0));
      check("rst_mid_in_ready", W'(in_ready), W'(1));
      check("rst_mid_result", Result, '0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      check("rst_mid_no_stale_result", W'(seen), W'(0));
      check("rst_mid_in_ready_after", W'(in_ready), W'(1));

      // Function still correct after the aborted operation
      do_op(OP_MUL, 32'd3, 32'd7, lat);
      check("post_rst_mul_latency", W'(lat), W'(33));
      check("post_rst_mul_result", Result, 32'd21);
      retire("post_rst_mul");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
